// File: rtl/gray_stream_pipe.sv
// Streaming RGB-to-gray converter: one frame per start command, 2-stage
// weighted-luma pipeline with valid/ready on both sides and raster markers.
module gray_stream_pipe #(
    parameter int DATA_W  = 10,
    parameter int FRAME_W = 640,
    parameter int FRAME_H = 480,
    parameter int COEF_W  = 8,
    parameter int W_RED   = 77,
    parameter int W_GREEN = 150,
    parameter int W_BLUE  = 29,
    parameter int SHIFT   = 8,
    localparam int XW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1,
    localparam int YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_threshold,
    output logic              o_read_request,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_red,
    input  logic [DATA_W-1:0] i_green,
    input  logic [DATA_W-1:0] i_blue,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_color,
    output logic              o_bw,
    output logic [XW-1:0]     o_x,
    output logic [YW-1:0]     o_y,
    output logic              o_sof,
    output logic              o_eol,
    output logic              o_eof,
    output logic              o_busy,
    output logic              o_done
);

    localparam int NPIX = FRAME_W * FRAME_H;
    localparam int CW   = $clog2(NPIX + 1);
    localparam int PW   = DATA_W + COEF_W;
    localparam int SW   = PW + 2;

    localparam logic [COEF_W-1:0] CR = COEF_W'(W_RED);
    localparam logic [COEF_W-1:0] CG = COEF_W'(W_GREEN);
    localparam logic [COEF_W-1:0] CB = COEF_W'(W_BLUE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RUN,
        S_DRAIN,
        S_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] thr_q, thr_d;
    logic [CW-1:0]     in_cnt_q, in_cnt_d;
    logic [XW-1:0]     in_x_q, in_x_d;
    logic [YW-1:0]     in_y_q, in_y_d;
    logic              done_q, done_d;

    logic              vld_p1_q, vld_p1_d;
    logic [PW-1:0]     prod_r_p1_q, prod_r_p1_d;
    logic [PW-1:0]     prod_g_p1_q, prod_g_p1_d;
    logic [PW-1:0]     prod_b_p1_q, prod_b_p1_d;
    logic [DATA_W-1:0] red_p1_q, red_p1_d;
    logic [XW-1:0]     x_p1_q, x_p1_d;
    logic [YW-1:0]     y_p1_q, y_p1_d;

    logic              vld_p2_q, vld_p2_d;
    logic [DATA_W-1:0] color_p2_q, color_p2_d;
    logic              bw_p2_q, bw_p2_d;
    logic [XW-1:0]     x_p2_q, x_p2_d;
    logic [YW-1:0]     y_p2_q, y_p2_d;
    logic              sof_p2_q, sof_p2_d;
    logic              eol_p2_q, eol_p2_d;
    logic              eof_p2_q, eof_p2_d;

    logic              adv;
    logic              in_hs;
    logic              out_hs;
    logic [SW-1:0]     sum_p2;
    logic [DATA_W-1:0] luma_p2;

    // Clamp the shifted weighted sum to the largest representable sample.
    function automatic logic [DATA_W-1:0] sat_luma(input logic [SW-1:0] sum);
        logic [SW-1:0] sh;
        sh = sum >> SHIFT;
        if (|sh[SW-1:DATA_W]) begin
            return {DATA_W{1'b1}};
        end
        return sh[DATA_W-1:0];
    endfunction

    assign adv    = !vld_p2_q || i_ready;
    assign o_ready = (state_q == S_RUN) && adv && (in_cnt_q < CW'(NPIX));
    assign in_hs  = i_valid && o_ready;
    assign out_hs = vld_p2_q && i_ready;

    assign o_read_request = (state_q == S_REQ);
    assign o_busy = (state_q == S_REQ) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign o_done = done_q;

    assign o_valid = vld_p2_q;
    assign o_color = color_p2_q;
    assign o_bw    = bw_p2_q;
    assign o_x     = x_p2_q;
    assign o_y     = y_p2_q;
    assign o_sof   = sof_p2_q;
    assign o_eol   = eol_p2_q;
    assign o_eof   = eof_p2_q;

    // Frame control and input-side raster position
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        thr_d    = thr_q;
        in_cnt_d = in_cnt_q;
        in_x_d   = in_x_q;
        in_y_d   = in_y_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    mode_d   = i_mode;
                    thr_d    = i_threshold;
                    in_cnt_d = '0;
                    in_x_d   = '0;
                    in_y_d   = '0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (in_hs) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_x_q == XW'(FRAME_W - 1)) begin
                        in_x_d = '0;
                        in_y_d = in_y_q + 1'b1;
                    end else begin
                        in_x_d = in_x_q + 1'b1;
                    end
                    if (in_cnt_q == CW'(NPIX - 1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (out_hs && eof_p2_q) begin
                    done_d  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!i_start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= '0;
            thr_q    <= '0;
            in_cnt_q <= '0;
            in_x_q   <= '0;
            in_y_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            thr_q    <= thr_d;
            in_cnt_q <= in_cnt_d;
            in_x_q   <= in_x_d;
            in_y_q   <= in_y_d;
            done_q   <= done_d;
        end
    end

    // Stage 1: per-channel weighted products
    always_comb begin
        vld_p1_d    = vld_p1_q;
        prod_r_p1_d = prod_r_p1_q;
        prod_g_p1_d = prod_g_p1_q;
        prod_b_p1_d = prod_b_p1_q;
        red_p1_d    = red_p1_q;
        x_p1_d      = x_p1_q;
        y_p1_d      = y_p1_q;
        if (adv) begin
            vld_p1_d    = in_hs;
            prod_r_p1_d = PW'(i_red) * PW'(CR);
            prod_g_p1_d = PW'(i_green) * PW'(CG);
            prod_b_p1_d = PW'(i_blue) * PW'(CB);
            red_p1_d    = i_red;
            x_p1_d      = in_x_q;
            y_p1_d      = in_y_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
        end
    end

    always_ff @(posedge i_clk) begin
        prod_r_p1_q <= prod_r_p1_d;
        prod_g_p1_q <= prod_g_p1_d;
        prod_b_p1_q <= prod_b_p1_d;
        red_p1_q    <= red_p1_d;
        x_p1_q      <= x_p1_d;
        y_p1_q      <= y_p1_d;
    end

    // Stage 2: sum, shift, saturate, mode select and raster markers
    always_comb begin
        sum_p2  = SW'(prod_r_p1_q) + SW'(prod_g_p1_q) + SW'(prod_b_p1_q);
        luma_p2 = sat_luma(sum_p2);

        vld_p2_d   = vld_p2_q;
        color_p2_d = color_p2_q;
        bw_p2_d    = bw_p2_q;
        x_p2_d     = x_p2_q;
        y_p2_d     = y_p2_q;
        sof_p2_d   = sof_p2_q;
        eol_p2_d   = eol_p2_q;
        eof_p2_d   = eof_p2_q;
        if (adv) begin
            vld_p2_d = vld_p1_q;
            bw_p2_d  = (luma_p2 <= thr_q);
            case (mode_q)
                2'd0:    color_p2_d = luma_p2;
                2'd1:    color_p2_d = (luma_p2 > thr_q) ? {DATA_W{1'b1}} : '0;
                2'd2:    color_p2_d = ~luma_p2;
                default: color_p2_d = red_p1_q;
            endcase
            x_p2_d   = x_p1_q;
            y_p2_d   = y_p1_q;
            sof_p2_d = (x_p1_q == '0) && (y_p1_q == '0);
            eol_p2_d = (x_p1_q == XW'(FRAME_W - 1));
            eof_p2_d = (x_p1_q == XW'(FRAME_W - 1)) && (y_p1_q == YW'(FRAME_H - 1));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p2_q   <= 1'b0;
            color_p2_q <= '0;
            bw_p2_q    <= 1'b0;
            x_p2_q     <= '0;
            y_p2_q     <= '0;
            sof_p2_q   <= 1'b0;
            eol_p2_q   <= 1'b0;
            eof_p2_q   <= 1'b0;
        end else begin
            vld_p2_q   <= vld_p2_d;
            color_p2_q <= color_p2_d;
            bw_p2_q    <= bw_p2_d;
            x_p2_q     <= x_p2_d;
            y_p2_q     <= y_p2_d;
            sof_p2_q   <= sof_p2_d;
            eol_p2_q   <= eol_p2_d;
            eof_p2_q   <= eof_p2_d;
        end
    end

endmodule

// File: tb/tb_gray_stream_pipe.sv
// Bench for gray_stream_pipe on a 4x2 frame: queue-based reference model
// checked every output cycle, plus directed frames and literal pins.
module tb_gray_stream_pipe;

    localparam int DW = 10;
    localparam int FW = 4;
    localparam int FH = 2;
    localparam int N  = FW * FH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start;
    logic [1:0]    i_mode;
    logic [DW-1:0] i_threshold;
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] i_red, i_green, i_blue;

    logic          o_read_request, o_ready, o_valid, o_bw, o_sof, o_eol, o_eof, o_busy, o_done;
    logic [DW-1:0] o_color;
    logic [1:0]    o_x;
    logic [0:0]    o_y;

    logic          s_read_request, s_ready, s_valid, s_bw, s_sof, s_eol, s_eof, s_busy, s_done;
    logic [DW-1:0] s_color;
    logic [1:0]    s_x;
    logic [0:0]    s_y;

    always #5 clk = ~clk;

    gray_stream_pipe #(.DATA_W(DW), .FRAME_W(FW), .FRAME_H(FH)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_mode(i_mode),
        .i_threshold(i_threshold), .o_read_request(o_read_request),
        .i_valid(i_valid), .o_ready(o_ready), .i_red(i_red), .i_green(i_green),
        .i_blue(i_blue), .o_valid(o_valid), .i_ready(i_ready), .o_color(o_color),
        .o_bw(o_bw), .o_x(o_x), .o_y(o_y), .o_sof(o_sof), .o_eol(o_eol),
        .o_eof(o_eof), .o_busy(o_busy), .o_done(o_done)
    );

    gray_stream_pipe #(.DATA_W(DW), .FRAME_W(FW), .FRAME_H(FH), .W_RED(200)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_mode(i_mode),
        .i_threshold(i_threshold), .o_read_request(s_read_request),
        .i_valid(i_valid), .o_ready(s_ready), .i_red(i_red), .i_green(i_green),
        .i_blue(i_blue), .o_valid(s_valid), .i_ready(i_ready), .o_color(s_color),
        .o_bw(s_bw), .o_x(s_x), .o_y(s_y), .o_sof(s_sof), .o_eol(s_eol),
        .o_eof(s_eof), .o_busy(s_busy), .o_done(s_done)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what a sample must be, from the pixel alone.
    function automatic int luma_of(input int r, input int g, input int b, input int wr);
        int s;
        s = (r * wr + g * 150 + b * 29) / 256;
        return (s > 1023) ? 1023 : s;
    endfunction

    function automatic int color_of(input int mode, input int thr, input int r,
                                    input int g, input int b, input int wr);
        int l;
        l = luma_of(r, g, b, wr);
        case (mode)
            0:       return l;
            1:       return (l > thr) ? 1023 : 0;
            2:       return 1023 - l;
            default: return r;
        endcase
    endfunction

    typedef struct {
        int r;
        int g;
        int b;
    } px_t;

    px_t q[$];
    int  cyc = 0;
    int  cur_mode, cur_thr;
    int  in_idx, out_idx, hs0_cyc;
    int  rq_cnt = 0, done_cnt = 0, out_cnt = 0;
    bit  eof_prev, rq_prev, first_seen;
    int  first_color, first_sat_color;
    int  pr[N], pg[N], pb[N];
    bit  pat_en = 1'b0;
    int  pat[4] = '{1, 0, 0, 1};

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        int pc;
        pc = 0;
        i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            i_ready = pat_en ? pat[pc % 4][0] : 1'b1;
            pc++;
        end
    end

    // Compare process: every negedge while out of reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            in_idx = 0;
            out_idx = 0;
            eof_prev = 1'b0;
            rq_prev = 1'b0;
            first_seen = 1'b0;
        end else begin
            if (o_read_request) begin
                check("rq_single_cycle", int'(rq_prev), 0);
                rq_cnt++;
                in_idx = 0;
                out_idx = 0;
                first_seen = 1'b0;
            end
            rq_prev = o_read_request;
            if (o_done || eof_prev) begin
                check("done_after_eof", int'(o_done), int'(eof_prev));
                if (o_done) begin
                    check("busy_low_at_done", int'(o_busy), 0);
                    done_cnt++;
                end
            end
            eof_prev = 1'b0;
            if (o_valid) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL out_unexpected: o_valid=1 with no pending pixel (t=%0t)", $time);
                end else begin
                    px_t p;
                    int l;
                    p = q[0];
                    l = luma_of(p.r, p.g, p.b, 77);
                    check("color", int'(o_color), color_of(cur_mode, cur_thr, p.r, p.g, p.b, 77));
                    check("bw", int'(o_bw), (l <= cur_thr) ? 1 : 0);
                    check("x", int'(o_x), out_idx % FW);
                    check("y", int'(o_y), out_idx / FW);
                    check("sof", int'(o_sof), (out_idx == 0) ? 1 : 0);
                    check("eol", int'(o_eol), (out_idx % FW == FW - 1) ? 1 : 0);
                    check("eof", int'(o_eof), (out_idx == N - 1) ? 1 : 0);
                    check("sat_color", int'(s_color), color_of(cur_mode, cur_thr, p.r, p.g, p.b, 200));
                    check("sat_valid", int'(s_valid), 1);
                    if (out_idx == 0 && !first_seen) begin
                        first_seen = 1'b1;
                        check("latency", cyc - hs0_cyc, 2);
                        first_color = int'(o_color);
                        first_sat_color = int'(s_color);
                    end
                    if (!i_ready) check("ready_low_in_stall", int'(o_ready), 0);
                    if (i_ready) begin
                        void'(q.pop_front());
                        if (o_eof) eof_prev = 1'b1;
                        out_idx++;
                        out_cnt++;
                    end
                end
            end
            if (i_valid && o_ready) begin
                px_t np;
                np.r = int'(i_red);
                np.g = int'(i_green);
                np.b = int'(i_blue);
                q.push_back(np);
                if (in_idx == 0) hs0_cyc = cyc;
                in_idx++;
            end
        end
    end

    task automatic load_px(input int k, input int r, input int g, input int b);
        pr[k] = r;
        pg[k] = g;
        pb[k] = b;
    endtask

    task automatic load_uniform(input int v);
        for (int k = 0; k < N; k++) load_px(k, v, v, v);
    endtask

    task automatic load_mixed();
        load_px(0, 512, 0, 0);
        load_px(1, 600, 600, 600);
        load_px(2, 0, 0, 0);
        load_px(3, 1023, 0, 0);
        load_px(4, 100, 200, 300);
        load_px(5, 300, 300, 300);
        load_px(6, 301, 301, 301);
        load_px(7, 1023, 1023, 1023);
    endtask

    task automatic start_frame(input int mode, input int thr);
        i_mode = mode[1:0];
        i_threshold = thr[DW-1:0];
        cur_mode = mode;
        cur_thr = thr;
        i_start = 1'b1;
    endtask

    // Feeds pixels 0..count-1; inputs change at posedge+1.
    task automatic feed(input int count);
        for (int p = 0; p < count; p++) begin
            bit acc;
            acc = 1'b0;
            i_valid = 1'b1;
            i_red = pr[p][DW-1:0];
            i_green = pg[p][DW-1:0];
            i_blue = pb[p][DW-1:0];
            for (int t = 0; t < 60 && !acc; t++) begin
                @(negedge clk);
                if (o_ready) acc = 1'b1;
                @(posedge clk);
                #1;
            end
            check("pixel_accept_timeout", int'(acc), 1);
        end
        i_valid = 1'b0;
    endtask

    task automatic run_frame(input int mode, input int thr, input bit use_pat);
        int rq0, done0, out0;
        bit got_done;
        rq0 = rq_cnt;
        done0 = done_cnt;
        out0 = out_cnt;
        pat_en = use_pat;
        start_frame(mode, thr);
        feed(N);
        got_done = 1'b0;
        for (int t = 0; t < 100 && !got_done; t++) begin
            @(negedge clk);
            if (o_done) got_done = 1'b1;
        end
        #1;
        check("done_seen", int'(got_done), 1);
        check("rq_pulses", rq_cnt - rq0, 1);
        check("outputs", out_cnt - out0, N);
        check("done_pulses", done_cnt - done0, 1);
        pat_en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("no_retrigger_rq", rq_cnt - rq0, 1);
        check("no_retrigger_busy", int'(o_busy), 0);
        i_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        i_start = 1'b0;
        i_mode = 2'd0;
        i_threshold = '0;
        i_valid = 1'b0;
        i_red = '0;
        i_green = '0;
        i_blue = '0;

        check("pin_luma_512", luma_of(512, 0, 0, 77), 154);
        check("pin_bin_512", color_of(1, 300, 512, 0, 0, 77), 0);
        check("pin_luma_600", luma_of(600, 600, 600, 77), 600);
        check("pin_bin_600", color_of(1, 300, 600, 600, 600, 77), 1023);
        check("pin_sat", luma_of(1023, 1023, 1023, 200), 1023);

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(o_valid), 0);
        check("rst_ready", int'(o_ready), 0);
        check("rst_rq", int'(o_read_request), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_color", int'(o_color), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        load_uniform(1023);
        run_frame(0, 300, 1'b0);
        check("frameA_first_color", first_color, 1023);
        check("frameA_sat_first_color", first_sat_color, 1023);

        load_mixed();
        run_frame(0, 300, 1'b0);
        check("frameB_mode0_first", first_color, 154);
        run_frame(1, 300, 1'b0);
        check("frameB_mode1_first", first_color, 0);
        run_frame(2, 300, 1'b1);
        check("frameB_mode2_first", first_color, 1023 - 154);
        run_frame(3, 300, 1'b1);
        check("frameB_mode3_first", first_color, 512);

        begin
            int d0;
            d0 = done_cnt;
            start_frame(0, 300);
            feed(3);
            #2;
            rst_n = 1'b0;
            #1;
            check("midrst_valid", int'(o_valid), 0);
            check("midrst_color", int'(o_color), 0);
            check("midrst_ready", int'(o_ready), 0);
            check("midrst_busy", int'(o_busy), 0);
            check("midrst_xy", int'(o_x) + int'(o_y), 0);
            check("midrst_markers", int'(o_sof) + int'(o_eol) + int'(o_eof) + int'(o_bw), 0);
            i_start = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            check("midrst_no_done", done_cnt - d0, 0);
            check("midrst_idle_busy", int'(o_busy), 0);
            check("midrst_idle_valid", int'(o_valid), 0);
        end

        load_mixed();
        run_frame(0, 300, 1'b1);
        check("after_rst_first", first_color, 154);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
